// File: rtl/uart_rx_ctrl_if.sv
// Bundle of receiver-side and host-side signals for uart_rx_ctrl.
// slave is the controller's view; master is the view of whatever drives it.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_SIZE = 7,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ERR_W     = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // receiver handshake
  logic                 enable;
  logic [DATA_SIZE-1:0] rx_data;
  logic                 rx_ready;
  logic                 rx_frame_error;
  logic                 rx_ack;

  // host read port
  logic [DATA_SIZE-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [CW-1:0]        fifo_count;

  // status
  logic                 overrun_flag;
  logic                 frame_err_flag;
  logic [ERR_W-1:0]     err_count;
  logic                 clr_status;

  modport slave (
    input  enable, rx_data, rx_ready, rx_frame_error, rd_ready, clr_status,
    output rx_ack, rd_data, rd_valid, fifo_count, overrun_flag, frame_err_flag, err_count
  );

  modport master (
    output enable, rx_data, rx_ready, rx_frame_error, rd_ready, clr_status,
    input  rx_ack, rd_data, rd_valid, fifo_count, overrun_flag, frame_err_flag, err_count
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures frames on a rising edge of rx_ready,
// filters them (enable / frame error / overrun), buffers good characters in a
// small FIFO and returns a one-cycle acknowledge to the receiver.
module uart_rx_ctrl #(
  parameter int unsigned DATA_SIZE = 7,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ERR_W     = 8
) (
  input logic            clk,
  input logic            res,
  uart_rx_ctrl_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EVAL, ACK} state_t;

  state_t               state, state_nxt;
  logic                 rdy_prev;
  logic [DATA_SIZE-1:0] hold_data;
  logic                 hold_err;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [ERR_W-1:0]     err_cnt;
  logic                 ovr_flag, ferr_flag, ack_q;
  logic                 not_empty, full, pop;
  logic                 capture, push, set_ovr, set_ferr;

  assign not_empty = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = not_empty & bus.rd_ready;

  assign bus.rd_valid       = not_empty;
  assign bus.rd_data        = not_empty ? mem[rd_ptr] : '0;
  assign bus.fifo_count     = count;
  assign bus.rx_ack         = ack_q;
  assign bus.overrun_flag   = ovr_flag;
  assign bus.frame_err_flag = ferr_flag;
  assign bus.err_count      = err_cnt;

  // FSM state register
  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state and per-frame action decode
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    push      = 1'b0;
    set_ovr   = 1'b0;
    set_ferr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.rx_ready && !rdy_prev) begin
          capture   = 1'b1;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        state_nxt = ACK;
        if (!bus.enable)        ;
        else if (hold_err)      set_ferr = 1'b1;
        else if (full && !pop)  set_ovr  = 1'b1;
        else                    push     = 1'b1;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rx_ready history, frame holding registers and registered acknowledge
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rdy_prev  <= 1'b1;
      hold_data <= '0;
      hold_err  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      rdy_prev <= bus.rx_ready;
      ack_q    <= (state_nxt == ACK);
      if (capture) begin
        hold_data <= bus.rx_data;
        hold_err  <= bus.rx_frame_error;
      end
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= hold_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // sticky status; a set event in the same cycle as clr_status takes precedence
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ovr_flag  <= 1'b0;
      ferr_flag <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (set_ovr)             ovr_flag <= 1'b1;
      else if (bus.clr_status) ovr_flag <= 1'b0;

      if (set_ferr)            ferr_flag <= 1'b1;
      else if (bus.clr_status) ferr_flag <= 1'b0;

      if (set_ferr) begin
        if (bus.clr_status)     err_cnt <= ERR_W'(1);
        else if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      end else if (bus.clr_status) begin
        err_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. Two instances share the stimulus:
// the default build and one with a 2-bit error counter for saturation.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_SIZE(7), .DEPTH(4), .ERR_W(8)) bus ();
  uart_rx_ctrl_if #(.DATA_SIZE(7), .DEPTH(4), .ERR_W(2)) bus2 ();

  assign bus2.enable         = bus.enable;
  assign bus2.rx_data        = bus.rx_data;
  assign bus2.rx_ready       = bus.rx_ready;
  assign bus2.rx_frame_error = bus.rx_frame_error;
  assign bus2.rd_ready       = bus.rd_ready;
  assign bus2.clr_status     = bus.clr_status;

  uart_rx_ctrl #(.DATA_SIZE(7), .DEPTH(4), .ERR_W(8)) dut  (.clk(clk), .res(res), .bus(bus));
  uart_rx_ctrl #(.DATA_SIZE(7), .DEPTH(4), .ERR_W(2)) dut2 (.clk(clk), .res(res), .bus(bus2));

  // reference model: queue of characters plus status
  int unsigned q[$];
  bit          m_ovr, m_ferr;
  int          m_err8, m_err2;
  int          nchecks = 0;
  int          nerrors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr = 0; m_ferr = 0; m_err8 = 0; m_err2 = 0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ":count"}, bus.fifo_count, q.size());
    chk({tag, ":valid"}, bus.rd_valid, q.size() > 0);
    chk({tag, ":data"},  bus.rd_data, (q.size() > 0) ? q[0] : 0);
    chk({tag, ":ovr"},   bus.overrun_flag, m_ovr);
    chk({tag, ":ferr"},  bus.frame_err_flag, m_ferr);
    chk({tag, ":err8"},  bus.err_count, m_err8);
    chk({tag, ":err2"},  bus2.err_count, m_err2);
  endtask

  // one receiver frame; do_pop / do_clr are applied on the evaluation edge
  task automatic send_frame(input int unsigned d, input bit err, input bit en,
                            input bit do_pop, input bit do_clr);
    bit was_full, popped;
    int waited;
    @(negedge clk);
    bus.rx_data = d[6:0]; bus.rx_frame_error = err; bus.enable = en; bus.rx_ready = 1'b1;
    @(negedge clk);
    chk("ack_early", bus.rx_ack, 0);
    popped = 0;
    if (do_pop) begin
      bus.rd_ready = 1'b1;
      if (q.size() > 0) begin
        chk("eval_pop_data", bus.rd_data, q[0]);
        popped = 1;
      end
    end
    bus.clr_status = do_clr;
    was_full = (q.size() == DEPTH);
    @(negedge clk);
    bus.rd_ready = 1'b0; bus.clr_status = 1'b0;
    if (popped) void'(q.pop_front());
    if (do_clr) begin m_ovr = 0; m_ferr = 0; m_err8 = 0; m_err2 = 0; end
    if (!en) ;
    else if (err) begin
      m_ferr = 1;
      m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
      m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
    end else if (was_full && !popped) m_ovr = 1;
    else q.push_back(d & 32'h7f);
    chk("ack_latency", bus.rx_ack, 1);
    chk("valid_k1", bus.rd_valid, q.size() > 0);
    waited = 0;
    while (bus.rx_ack !== 1'b1 && waited < 8) begin @(negedge clk); waited++; end
    bus.rx_ready = 1'b0;
    @(negedge clk);
    chk("ack_pulse", bus.rx_ack, 0);
    check_status("frame");
  endtask

  task automatic pop_one();
    @(negedge clk);
    if (q.size() > 0) begin
      chk("pop_data", bus.rd_data, q[0]);
      bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.rd_ready = 1'b0;
      void'(q.pop_front());
    end else begin
      chk("pop_empty_valid", bus.rd_valid, 0);
      bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.rd_ready = 1'b0;
    end
    check_status("pop");
  endtask

  task automatic pulse_clr();
    @(negedge clk); bus.clr_status = 1'b1;
    @(negedge clk); bus.clr_status = 1'b0;
    m_ovr = 0; m_ferr = 0; m_err8 = 0; m_err2 = 0;
    check_status("clr");
  endtask

  initial begin
    int acks;
    res = 1'b0;
    bus.enable = 1'b1; bus.rx_data = '0; bus.rx_ready = 1'b0; bus.rx_frame_error = 1'b0;
    bus.rd_ready = 1'b0; bus.clr_status = 1'b0;
    model_reset();
    #12;
    chk("rst_ack", bus.rx_ack, 0);
    check_status("reset");
    @(negedge clk); res = 1'b1;

    // single frame, then pop, then pop on empty
    send_frame(32'h55, 0, 1, 0, 0);
    chk("single_data", bus.rd_data, 32'h55);
    chk("single_count", bus.fifo_count, 1);
    pop_one();
    chk("single_drained", bus.fifo_count, 0);
    pop_one();

    // fill and overrun
    for (int i = 1; i <= 5; i++) send_frame(i, 0, 1, 0, 0);
    chk("fill_count", bus.fifo_count, 4);
    chk("fill_ovr", bus.overrun_flag, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("fill_order", bus.rd_data, i);
      pop_one();
    end

    // full with pop on the evaluation edge
    pulse_clr();
    for (int i = 1; i <= 4; i++) send_frame(i, 0, 1, 0, 0);
    send_frame(5, 0, 1, 1, 0);
    chk("fullpop_ovr", bus.overrun_flag, 0);
    chk("fullpop_count", bus.fifo_count, 4);
    for (int i = 0; i < 4; i++) pop_one();
    chk("fullpop_empty", bus.fifo_count, 0);

    // frame errors, clear coincident with an error, saturation
    for (int i = 0; i < 3; i++) send_frame(32'h7f, 1, 1, 0, 0);
    chk("err3", bus.err_count, 3);
    send_frame(32'h10, 1, 1, 0, 1);
    chk("err_clr_set", bus.err_count, 1);
    chk("err_clr_flag", bus.frame_err_flag, 1);
    pulse_clr();
    for (int i = 0; i < 5; i++) send_frame(i, 1, 1, 0, 0);
    chk("sat_err2", bus2.err_count, 3);
    chk("sat_err8", bus.err_count, 5);

    // disabled frame is discarded without touching status
    send_frame(32'h22, 0, 0, 0, 0);
    send_frame(32'h23, 1, 0, 0, 0);

    // reset in EVAL, with rx_ready held through the release
    send_frame(32'h11, 0, 1, 0, 0);
    @(negedge clk);
    bus.rx_data = 7'h2a; bus.rx_frame_error = 1'b0; bus.rx_ready = 1'b1;
    @(negedge clk);
    res = 1'b0;
    #1;
    model_reset();
    chk("async_count", bus.fifo_count, 0);
    chk("async_ack", bus.rx_ack, 0);
    @(negedge clk); res = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rx_ack === 1'b1) acks++;
    end
    chk("held_no_capture", acks, 0);
    check_status("after_reset");
    bus.rx_ready = 1'b0;
    send_frame(32'h33, 0, 1, 0, 0);
    chk("retoggle_data", bus.rd_data, 32'h33);
    pop_one();

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      send_frame($urandom_range(0, 127), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 11) == 0));
      if ($urandom_range(0, 2) == 0) pop_one();
    end
    while (q.size() > 0) pop_one();
    check_status("final");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
